mdu_multicycle: RTL and testbench
=================================

// Module: mdu_multicycle
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit holding the HI/LO architectural registers.
//   Executes MULT/MULTU/DIV/DIVU/MADD/MSUB and MTHI/MTLO issued from the E stage.
//   Exposes busy and a stall request so D-stage MFHI/MFLO/MD-class instructions wait until HI/LO are final.
// PARAMETERS
//   WIDTH        32   operand and HI/LO width
//   MULT_CYCLES  5    busy cycles for MULT/MULTU/MADD/MSUB (>=1)
//   DIV_CYCLES   10   busy cycles for DIV/DIVU (>=1)
//   CNT_W        4    counter width; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       E-stage MD instruction valid this cycle
//   op         in   3       0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MADD,7 MSUB
//   a          in   WIDTH   rs operand (dividend / multiplicand / MT source)
//   b          in   WIDTH   rt operand (divisor / multiplier)
//   cancel     in   1       abort in-flight op (pipeline flush)
//   md_use_d   in   1       D-stage instr is MD-class (MFHI/MFLO/MT*/MULT.../DIV...)
//   hi         out  WIDTH   architectural HI
//   lo         out  WIDTH   architectural LO
//   busy       out  1       operation in flight
//   stall_req  out  1       = md_use_d & (busy | start); combinational
// BEHAVIOUR
//   Reset (async, rst_n=0): hi=0, lo=0, busy=0, counter=0, pending regs=0, state IDLE.
//   States: IDLE, RUN.
//   IDLE, start=1, op in {0,1,2,3,6,7}: result computed from a,b (and current hi/lo for MADD/MSUB)
//     into pending_hi/pending_lo; counter<=MULT_CYCLES or DIV_CYCLES; -> RUN; busy=1 from next cycle.
//   IDLE, start=1, op=4/5: hi<=a / lo<=a at that edge; busy stays 0; no RUN.
//   RUN: counter decrements each cycle; busy=1 for exactly N cycles (N = op latency).
//     On the edge where counter 1->0: hi<=pending_hi, lo<=pending_lo, -> IDLE, busy=0 next cycle.
//     HI/LO visible to MFHI exactly N+1 cycles after the start edge's cycle (edge k start, hi valid after edge k+N).
//   start while busy=1: ignored (stall_req guarantees it cannot occur legally; no state change).
//   cancel=1: in RUN -> IDLE immediately at the edge, hi/lo unchanged, pending discarded.
//     cancel with start same cycle: cancel wins, op not accepted (including MTHI/MTLO).
//   Arithmetic:
//     MULT: {hi,lo} = signed a*b, 2*WIDTH product.  MULTU: unsigned.
//     MADD/MSUB: {hi,lo} = {hi,lo} +/- signed a*b, mod 2^(2*WIDTH); uses hi/lo at accept edge.
//     DIV: lo=quotient truncated toward zero, hi=remainder with sign of dividend.
//     DIVU: unsigned quotient/remainder.
//     b==0 for DIV/DIVU: full latency still elapses, hi/lo left unchanged.
//     DIV with a=MIN_INT, b=-1: lo=MIN_INT, hi=0 (wrap, no trap).
//   Reset asserted mid-RUN: all state cleared asynchronously, result lost.
//   stall_req is purely combinational; no registered path from md_use_d.
// TESTING
//   MULT a=-3 b=7 -> busy high 5 cycles; then hi=FFFFFFFF, lo=FFFFFFEB.
//   MULTU a=FFFFFFFF b=2 -> hi=1, lo=FFFFFFFE after 5 cycles; stall_req=1 while md_use_d=1 and busy=1.
//   DIV a=-7 b=2 -> after 10 cycles lo=FFFFFFFD, hi=FFFFFFFF; DIV b=0 -> hi/lo unchanged, busy 10 cycles.
//   MTHI a=1234 then MADD a=2 b=3 with lo=5 -> hi=1234, lo=B after MULT_CYCLES.
//   DIVU started, cancel at cycle 4 -> busy=0 next cycle, hi/lo unchanged; later start accepted.
//   rst_n low mid-RUN -> hi=lo=0, busy=0 immediately (no clock edge needed).

Source files
------------

// File: rtl/mdu_multicycle_if.sv
// Handshake and result bundle between the E-stage issue logic and the multiply/divide unit.
interface mdu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             md_use_d;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall_req;

  modport master (
    output start, op, a, b, cancel, md_use_d,
    input  hi, lo, busy, stall_req
  );

  modport slave (
    input  start, op, a, b, cancel, md_use_d,
    output hi, lo, busy, stall_req
  );
endinterface

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at accept time and
// held in pending registers; HI/LO are committed only when the latency counter expires.
module mdu_multicycle #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mdu_multicycle_if.slave md
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic [2*WIDTH-1:0] a_sext, b_sext, a_zext, b_zext;
  logic [2*WIDTH-1:0] sprod, uprod, acc, res;
  logic               a_neg, b_neg, b_zero, is_div;
  logic [WIDTH-1:0]   div_n, div_d, quo, rem, squot, srem;

  // Signed and unsigned products share the same low 2*WIDTH bits once the operands
  // are sign- or zero-extended to full width, so plain unsigned multipliers suffice.
  always_comb begin
    a_sext = {{WIDTH{md.a[WIDTH-1]}}, md.a};
    b_sext = {{WIDTH{md.b[WIDTH-1]}}, md.b};
    a_zext = {{WIDTH{1'b0}}, md.a};
    b_zext = {{WIDTH{1'b0}}, md.b};
    sprod  = a_sext * b_sext;
    uprod  = a_zext * b_zext;
    acc    = {hi_q, lo_q};
  end

  // One unsigned divider serves both DIV and DIVU; signed division runs on magnitudes
  // and fixes signs afterwards. MIN_INT / -1 wraps to MIN_INT with zero remainder.
  always_comb begin
    a_neg  = (md.op == OP_DIV) && md.a[WIDTH-1];
    b_neg  = (md.op == OP_DIV) && md.b[WIDTH-1];
    b_zero = (md.b == '0);
    div_n  = a_neg ? -md.a : md.a;
    div_d  = b_neg ? -md.b : md.b;
    if (b_zero) begin
      quo = '0;
      rem = '0;
    end else begin
      quo = div_n / div_d;
      rem = div_n % div_d;
    end
    squot = (a_neg ^ b_neg) ? -quo : quo;
    srem  = a_neg ? -rem : rem;
  end

  always_comb begin
    res = acc;
    unique case (md.op)
      OP_MULT:  res = sprod;
      OP_MULTU: res = uprod;
      OP_MADD:  res = acc + sprod;
      OP_MSUB:  res = acc - sprod;
      OP_DIV:   res = b_zero ? acc : {srem, squot};
      OP_DIVU:  res = b_zero ? acc : {rem, quo};
      default:  res = acc;
    endcase
  end

  assign is_div = (md.op == OP_DIV) || (md.op == OP_DIVU);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (md.start && !md.cancel) begin
          if (md.op == OP_MTHI) begin
            hi_d = md.a;
          end else if (md.op == OP_MTLO) begin
            lo_d = md.a;
          end else begin
            {pend_hi_d, pend_lo_d} = res;
            cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (md.cancel) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          pend_hi_d = '0;
          pend_lo_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            hi_d    = pend_hi_q;
            lo_d    = pend_lo_q;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.busy      = (state_q == S_RUN);
  assign md.stall_req = md.md_use_d & ((state_q == S_RUN) | md.start);

endmodule

// File: tb/tb_mdu_multicycle.sv
// Bench for mdu_multicycle: directed vector table, multi-cycle corner sequences and a
// randomized run against a plain-arithmetic model of HI/LO.
module tb_mdu_multicycle;

  localparam int unsigned W     = 32;
  localparam int unsigned MULTC = 5;
  localparam int unsigned DIVC  = 10;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] mhi, mlo;

  mdu_multicycle_if #(.WIDTH(W)) md ();

  mdu_multicycle #(
    .WIDTH      (W),
    .MULT_CYCLES(MULTC),
    .DIV_CYCLES (DIVC),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .md   (md)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    @(negedge clk);
    md.start = 1'b1;
    md.op    = op;
    md.a     = a;
    md.b     = b;
    @(negedge clk);
    md.start = 1'b0;
    n = 0;
    while (md.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Architectural effect of one accepted instruction on the model HI/LO pair.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
    longint      sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    cyc = 0;
    case (op)
      3'd0: begin p = sa * sb; {mhi, mlo} = p; cyc = MULTC; end
      3'd1: begin p = ua * ub; {mhi, mlo} = p; cyc = MULTC; end
      3'd6: begin p = sa * sb; {mhi, mlo} = {mhi, mlo} + p; cyc = MULTC; end
      3'd7: begin p = sa * sb; {mhi, mlo} = {mhi, mlo} - p; cyc = MULTC; end
      3'd2: begin
        cyc = DIVC;
        if (b != 0) begin
          q = sa / sb;
          r = sa % sb;
          mlo = q[31:0];
          mhi = r[31:0];
        end
      end
      3'd3: begin
        cyc = DIVC;
        if (b != 0) begin
          p = ua / ub;
          mlo = p[31:0];
          p = ua % ub;
          mhi = p[31:0];
        end
      end
      3'd4: mhi = a;
      default: mlo = a;
    endcase
  endtask

  initial begin
    int n, cyc;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    total = 0;
    bad   = 0;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, MULTC};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, MULTC};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIVC};
    vecs[3]  = '{3'd2, 32'h0000_0005, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIVC};
    vecs[4]  = '{3'd4, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFD, 0};
    vecs[5]  = '{3'd5, 32'h0000_0005, 32'd0,         32'h0000_1234, 32'h0000_0005, 0};
    vecs[6]  = '{3'd6, 32'h0000_0002, 32'd3,         32'h0000_1234, 32'h0000_000B, MULTC};
    vecs[7]  = '{3'd7, 32'h0000_0004, 32'd3,         32'h0000_1233, 32'hFFFF_FFFF, MULTC};
    vecs[8]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIVC};
    vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999, DIVC};
    vecs[10] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIVC};
    vecs[11] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULTC};
    vecs[12] = '{3'd3, 32'h1234_5678, 32'd0,         32'h4000_0000, 32'h0000_0000, DIVC};

    rst_n       = 1'b0;
    md.start    = 1'b0;
    md.op       = 3'd0;
    md.a        = '0;
    md.b        = '0;
    md.cancel   = 1'b0;
    md.md_use_d = 1'b0;
    #22 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_hi", 64'(md.hi), 64'd0);
    chk("reset_lo", 64'(md.lo), 64'd0);
    chk("reset_busy", 64'(md.busy), 64'd0);

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(n), 64'(vecs[i].cyc));
      chk($sformatf("vec%0d_hi", i), 64'(md.hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(md.lo), 64'(vecs[i].lo));
    end
    mhi = 32'h4000_0000;
    mlo = 32'h0000_0000;

    // Stall request: combinational from start, held by busy, gated by md_use_d.
    @(negedge clk);
    md.md_use_d = 1'b1;
    md.start = 1'b1; md.op = 3'd0; md.a = 32'd9; md.b = 32'd9;
    #1 chk("stall_on_start", 64'(md.stall_req), 64'd1);
    @(negedge clk);
    md.start = 1'b0;
    #1 chk("stall_on_busy", 64'(md.stall_req), 64'd1);
    md.md_use_d = 1'b0;
    #1 chk("stall_gated", 64'(md.stall_req), 64'd0);
    md.md_use_d = 1'b1;
    n = 1;
    @(negedge clk);
    while (md.busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    model_op(3'd0, 32'd9, 32'd9, cyc);
    chk("stall_seq_cycles", 64'(n), 64'(cyc));
    chk("stall_idle", 64'(md.stall_req), 64'd0);
    chk("stall_seq_lo", 64'(md.lo), 64'(mlo));
    md.md_use_d = 1'b0;

    // Cancel in RUN: abort, HI/LO untouched, next op accepted normally.
    @(negedge clk);
    md.start = 1'b1; md.op = 3'd3; md.a = 32'd100; md.b = 32'd7;
    @(negedge clk);
    md.start = 1'b0;
    chk("cancel_busy_before", 64'(md.busy), 64'd1);
    repeat (2) @(negedge clk);
    md.cancel = 1'b1;
    @(negedge clk);
    md.cancel = 1'b0;
    chk("cancel_busy_after", 64'(md.busy), 64'd0);
    chk("cancel_hi", 64'(md.hi), 64'(mhi));
    chk("cancel_lo", 64'(md.lo), 64'(mlo));
    do_op(3'd1, 32'd6, 32'd7, n);
    model_op(3'd1, 32'd6, 32'd7, cyc);
    chk("after_cancel_cycles", 64'(n), 64'(cyc));
    chk("after_cancel_lo", 64'(md.lo), 64'(mlo));

    // Cancel together with start: neither MTHI nor MULT is accepted.
    @(negedge clk);
    md.start = 1'b1; md.cancel = 1'b1; md.op = 3'd4; md.a = 32'hFACE;
    @(negedge clk);
    md.op = 3'd0; md.a = 32'd3; md.b = 32'd3;
    chk("cancel_start_mthi", 64'(md.hi), 64'(mhi));
    @(negedge clk);
    md.start = 1'b0; md.cancel = 1'b0;
    chk("cancel_start_mult_busy", 64'(md.busy), 64'd0);
    chk("cancel_start_lo", 64'(md.lo), 64'(mlo));

    // Start while busy is ignored.
    @(negedge clk);
    md.start = 1'b1; md.op = 3'd0; md.a = 32'd3; md.b = 32'd5;
    @(negedge clk);
    md.op = 3'd5; md.a = 32'hDEAD_BEEF;
    n = 1;
    @(negedge clk);
    md.start = 1'b0;
    while (md.busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    model_op(3'd0, 32'd3, 32'd5, cyc);
    chk("busy_start_cycles", 64'(n), 64'(cyc));
    chk("busy_start_lo", 64'(md.lo), 64'(mlo));
    chk("busy_start_hi", 64'(md.hi), 64'(mhi));

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(7));
      ra  = $urandom;
      case ($urandom_range(7))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = 32'($urandom_range(15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(5) == 0) ra = 32'h8000_0000;
      do_op(rop, ra, rb, n);
      model_op(rop, ra, rb, cyc);
      chk($sformatf("rnd%0d_op%0d_cycles", i, rop), 64'(n), 64'(cyc));
      chk($sformatf("rnd%0d_op%0d_hilo", i, rop), {md.hi, md.lo}, {mhi, mlo});
    end

    // Asynchronous reset mid-RUN clears everything without a clock edge.
    do_op(3'd4, 32'hAAAA_5555, 32'd0, n);
    @(negedge clk);
    md.start = 1'b1; md.op = 3'd2; md.a = 32'd50; md.b = 32'd3;
    @(negedge clk);
    md.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_hi", 64'(md.hi), 64'd0);
    chk("rst_mid_lo", 64'(md.lo), 64'd0);
    chk("rst_mid_busy", 64'(md.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DIVC + 2) @(negedge clk);
    chk("rst_result_lost", {md.hi, md.lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
